// File: rtl/clk_pkg.sv
// Shared definitions for the digital clock counters: digit width, hour limits
// and two-digit BCD increment/decrement helpers.
package clk_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam logic [7:0]  HR_MAX_BCD  = 8'h23;
    localparam logic [7:0]  HR_NOON_BCD = 8'h12;

    // Two-digit BCD increment that wraps to 00 after max_val (e.g. 8'h23, 8'h59).
    function automatic logic [7:0] bcd2_inc(input logic [7:0] val, input logic [7:0] max_val);
        if (val == max_val)
            return 8'h00;
        if (val[3:0] == 4'd9)
            return {val[7:4] + 4'd1, 4'd0};
        return {val[7:4], val[3:0] + 4'd1};
    endfunction

    // Two-digit BCD decrement that wraps from 00 to max_val.
    function automatic logic [7:0] bcd2_dec(input logic [7:0] val, input logic [7:0] max_val);
        if (val == 8'h00)
            return max_val;
        if (val[3:0] == 4'd0)
            return {val[7:4] - 4'd1, 4'd9};
        return {val[7:4], val[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/hour_fmt_12_24.sv
// Combinational mapping of the 00-23 BCD hour onto 12/24-hour display digits
// plus the PM flag.
module hour_fmt_12_24
    import clk_pkg::*;
#(
    parameter logic [7:0] MIDNIGHT_12H = 8'h12
) (
    input  logic [7:0] hr,
    input  logic       mode_12,
    output logic [7:0] disp,
    output logic       pm
);

    logic w_afternoon;

    // Valid BCD orders like binary, so a plain magnitude compare is safe.
    assign w_afternoon = (hr > HR_NOON_BCD);
    assign pm          = (hr >= HR_NOON_BCD);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        disp = hr;
        if (mode_12) begin
            if (hr == 8'h00) begin
                disp = MIDNIGHT_12H;
            end else if (w_afternoon) begin
                // BCD subtract 12: borrow from tens when units < 2.
                if (hr[3:0] >= 4'd2)
                    disp = {hr[7:4] - 4'd1, hr[3:0] - 4'd2};
                else
                    disp = {hr[7:4] - 4'd2, hr[3:0] + 4'd8};
            end
        end
    end

endmodule

// File: rtl/hour_counter_12_24.sv
// BCD hour-of-day counter (00-23) with manual set, checked direct load, day
// carry and registered 12/24-hour display outputs.
module hour_counter_12_24
    import clk_pkg::*;
#(
    parameter int unsigned DIGIT_W      = clk_pkg::DIGIT_W,
    parameter logic [7:0]  MIDNIGHT_12H = 8'h12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hr_tick,
    input  logic               set_mode,
    input  logic               inc,
    input  logic               dec,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_h,
    input  logic [DIGIT_W-1:0] load_l,
    input  logic               mode_12,
    output logic [DIGIT_W-1:0] disp_h,
    output logic [DIGIT_W-1:0] disp_l,
    output logic               pm,
    output logic               day_carry,
    output logic               load_err
);

    logic [7:0] r_hr;
    logic [7:0] r_disp;
    logic       r_pm;
    logic       r_day_carry;
    logic       r_load_err;

    logic [7:0] w_load_val;
    logic       w_load_ok;
    logic       w_tick;
    logic [7:0] w_fmt_disp;
    logic       w_fmt_pm;

    assign w_load_val = {load_h, load_l};
    assign w_load_ok  = (load_l <= 4'd9) && (w_load_val <= HR_MAX_BCD);
    assign w_tick     = hr_tick && !set_mode && !load;

    hour_fmt_12_24 #(
        .MIDNIGHT_12H(MIDNIGHT_12H)
    ) u_fmt (
        .hr     (r_hr),
        .mode_12(mode_12),
        .disp   (w_fmt_disp),
        .pm     (w_fmt_pm)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hr        <= 8'h00;
            r_disp      <= 8'h00;
            r_pm        <= 1'b0;
            r_day_carry <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_disp      <= w_fmt_disp;
            r_pm        <= w_fmt_pm;
            r_day_carry <= w_tick && (r_hr == HR_MAX_BCD);
            r_load_err  <= load && !w_load_ok;

            if (load) begin
                if (w_load_ok)
                    r_hr <= w_load_val;
            end else if (set_mode && inc) begin
                r_hr <= bcd2_inc(r_hr, HR_MAX_BCD);
            end else if (set_mode && dec) begin
                r_hr <= bcd2_dec(r_hr, HR_MAX_BCD);
            end else if (w_tick) begin
                r_hr <= bcd2_inc(r_hr, HR_MAX_BCD);
            end
        end
    end

    assign disp_h    = r_disp[7:4];
    assign disp_l    = r_disp[3:0];
    assign pm        = r_pm;
    assign day_carry = r_day_carry;
    assign load_err  = r_load_err;

endmodule
